colour_filter_pipe: RTL and testbench

//  Parametrised streaming colour filter between the D8M RGB output and the VGA DAC.

---
 rtl/colour_filter_pipe.sv | 190 +++++++++++++++++++
 tb/tb_colour_filter_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/colour_filter_pipe.sv
// colour_filter_pipe
//   Streaming colour filter between the camera RGB stream and the VGA DAC.
//   It is a fixed three-stage pipeline with no back-pressure. It has four modes:
//   pass, greyscale, channel mask and colour key. Configuration is written into
//   pending registers. It becomes active only at a frame start, which is the
//   rising edge of iVS. In colour-key mode the block counts matching pixels per
//   frame and reports the total when the frame edge leaves the pipeline.
// Ports
//   iCLK, iRST               pixel clock, synchronous active-high reset
//   iVS, iDE, iR/iG/iB       input frame sync, pixel valid and pixel
//   iMODE, iMASK, iKEY_CH,
//   iTHRESH, iCFG_WR         configuration fields and their write strobe
//   oR/oG/oB, oDE, oVS       filtered pixel, valid and sync (3-cycle latency)
//   oMATCH_CNT, oCNT_VALID   matched-pixel count of the previous frame + pulse
module colour_filter_pipe #(
  parameter int CW    = 8,
  parameter int CNT_W = 20
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iVS,
  input  logic             iDE,
  input  logic [CW-1:0]    iR,
  input  logic [CW-1:0]    iG,
  input  logic [CW-1:0]    iB,
  input  logic [1:0]       iMODE,
  input  logic [2:0]       iMASK,
  input  logic [1:0]       iKEY_CH,
  input  logic [CW-1:0]    iTHRESH,
  input  logic             iCFG_WR,
  output logic [CW-1:0]    oR,
  output logic [CW-1:0]    oG,
  output logic [CW-1:0]    oB,
  output logic             oDE,
  output logic             oVS,
  output logic [CNT_W-1:0] oMATCH_CNT,
  output logic             oCNT_VALID
);

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_GREY = 2'd1;
  localparam logic [1:0] MODE_MASK = 2'd2;
  localparam logic [1:0] MODE_KEY  = 2'd3;

  logic            vs_prev_q;
  logic [1:0]      pend_mode_q, act_mode_q;
  logic [2:0]      pend_mask_q, act_mask_q;
  logic [1:0]      pend_key_q,  act_key_q;
  logic [CW-1:0]   pend_thr_q,  act_thr_q;

  logic [CW-1:0]   r1_q, g1_q, b1_q, y1_q, thr1_q;
  logic            de1_q, vs1_q;
  logic [1:0]      mode1_q, key1_q;
  logic [2:0]      mask1_q;

  logic [CW-1:0]   r2_q, g2_q, b2_q, y2_q;
  logic            de2_q, vs2_q, match2_q;
  logic [1:0]      mode2_q;
  logic [2:0]      mask2_q;

  logic [CW-1:0]   or_q, og_q, ob_q, or_d, og_d, ob_d;
  logic            de3_q, vs3_q;
  logic [CNT_W-1:0] acc_q, acc_d, cnt_q, cnt_d;
  logic            cnt_valid_q, cnt_valid_d;

  logic            vs_edge;
  logic [1:0]      new_mode, eff_mode, new_key, eff_key;
  logic [2:0]      new_mask, eff_mask;
  logic [CW-1:0]   new_thr, eff_thr, y_in;
  logic [CW-1:0]   k_ch, o1_ch, o2_ch;
  logic            match_s2, hit, s3_edge;

  // The pixel arriving with the frame edge already belongs to the new frame,
  // so it travels with the freshly activated configuration.
  // A write coincident with the edge takes effect immediately.
  assign vs_edge  = iVS & ~vs_prev_q;
  assign new_mode = iCFG_WR ? iMODE   : pend_mode_q;
  assign new_mask = iCFG_WR ? iMASK   : pend_mask_q;
  assign new_key  = iCFG_WR ? iKEY_CH : pend_key_q;
  assign new_thr  = iCFG_WR ? iTHRESH : pend_thr_q;
  assign eff_mode = vs_edge ? new_mode : act_mode_q;
  assign eff_mask = vs_edge ? new_mask : act_mask_q;
  assign eff_key  = vs_edge ? new_key  : act_key_q;
  assign eff_thr  = vs_edge ? new_thr  : act_thr_q;

  assign y_in = CW'(({2'b00, iR} + {1'b0, iG, 1'b0} + {2'b00, iB}) >> 2);

  always_comb begin
    k_ch  = r1_q;
    o1_ch = g1_q;
    o2_ch = b1_q;
    case (key1_q)
      2'd1:    begin k_ch = g1_q; o1_ch = r1_q; o2_ch = b1_q; end
      2'd2:    begin k_ch = b1_q; o1_ch = r1_q; o2_ch = g1_q; end
      default: ;
    endcase
  end

  // One extra bit keeps other + threshold from wrapping past full scale.
  assign match_s2 = ({1'b0, k_ch} >= ({1'b0, o1_ch} + {1'b0, thr1_q})) &&
                    ({1'b0, k_ch} >= ({1'b0, o2_ch} + {1'b0, thr1_q}));

  always_comb begin
    or_d = '0;
    og_d = '0;
    ob_d = '0;
    if (de2_q) begin
      case (mode2_q)
        MODE_GREY: begin or_d = y2_q; og_d = y2_q; ob_d = y2_q; end
        MODE_MASK: begin
          or_d = mask2_q[2] ? r2_q : '0;
          og_d = mask2_q[1] ? g2_q : '0;
          ob_d = mask2_q[0] ? b2_q : '0;
        end
        MODE_KEY: begin
          or_d = match2_q ? r2_q : y2_q;
          og_d = match2_q ? g2_q : y2_q;
          ob_d = match2_q ? b2_q : y2_q;
        end
        default: begin or_d = r2_q; og_d = g2_q; ob_d = b2_q; end
      endcase
    end
  end

  // The frame boundary is seen as the sync edge leaving S2 into S3.
  // A matching pixel on that same cycle seeds the next frame's count.
  assign s3_edge = vs2_q & ~vs3_q;
  assign hit     = de2_q & (mode2_q == MODE_KEY) & match2_q;

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    cnt_valid_d = 1'b0;
    if (s3_edge) begin
      cnt_d       = acc_q;
      acc_d       = hit ? CNT_W'(1) : '0;
      cnt_valid_d = 1'b1;
    end else if (hit && !(&acc_q)) begin
      acc_d = acc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      vs_prev_q   <= 1'b0;
      pend_mode_q <= MODE_PASS; act_mode_q <= MODE_PASS;
      pend_mask_q <= 3'b111;    act_mask_q <= 3'b111;
      pend_key_q  <= 2'd0;      act_key_q  <= 2'd0;
      pend_thr_q  <= '0;        act_thr_q  <= '0;
      r1_q <= '0; g1_q <= '0; b1_q <= '0; y1_q <= '0; thr1_q <= '0;
      de1_q <= 1'b0; vs1_q <= 1'b0; mode1_q <= '0; key1_q <= '0; mask1_q <= '0;
      r2_q <= '0; g2_q <= '0; b2_q <= '0; y2_q <= '0;
      de2_q <= 1'b0; vs2_q <= 1'b0; match2_q <= 1'b0; mode2_q <= '0; mask2_q <= '0;
      or_q <= '0; og_q <= '0; ob_q <= '0; de3_q <= 1'b0; vs3_q <= 1'b0;
      acc_q <= '0; cnt_q <= '0; cnt_valid_q <= 1'b0;
    end else begin
      vs_prev_q <= iVS;
      if (iCFG_WR) begin
        pend_mode_q <= iMODE;
        pend_mask_q <= iMASK;
        pend_key_q  <= iKEY_CH;
        pend_thr_q  <= iTHRESH;
      end
      act_mode_q <= eff_mode;
      act_mask_q <= eff_mask;
      act_key_q  <= eff_key;
      act_thr_q  <= eff_thr;

      r1_q <= iR; g1_q <= iG; b1_q <= iB; y1_q <= y_in; thr1_q <= eff_thr;
      de1_q <= iDE; vs1_q <= iVS; mode1_q <= eff_mode; key1_q <= eff_key;
      mask1_q <= eff_mask;

      r2_q <= r1_q; g2_q <= g1_q; b2_q <= b1_q; y2_q <= y1_q;
      de2_q <= de1_q; vs2_q <= vs1_q; match2_q <= match_s2;
      mode2_q <= mode1_q; mask2_q <= mask1_q;

      or_q <= or_d; og_q <= og_d; ob_q <= ob_d; de3_q <= de2_q; vs3_q <= vs2_q;
      acc_q <= acc_d; cnt_q <= cnt_d; cnt_valid_q <= cnt_valid_d;
    end
  end

  assign oR         = or_q;
  assign oG         = og_q;
  assign oB         = ob_q;
  assign oDE        = de3_q;
  assign oVS        = vs3_q;
  assign oMATCH_CNT = cnt_q;
  assign oCNT_VALID = cnt_valid_q;

endmodule

// File: tb/tb_colour_filter_pipe.sv
module tb_colour_filter_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vs = 1'b0, de = 1'b0, cfg_wr = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0, thr_v = '0;
  logic [1:0] mode_v = '0, key_v = '0;
  logic [2:0] mask_v = 3'b111;

  logic [7:0]  o_r, o_g, o_b, o4_r, o4_g, o4_b;
  logic        o_de, o_vs, o_cv, o4_de, o4_vs, o4_cv;
  logic [19:0] o_cnt;
  logic [3:0]  o4_cnt;

  always #5 clk = ~clk;

  colour_filter_pipe dut (
    .iCLK(clk), .iRST(rst), .iVS(vs), .iDE(de), .iR(r), .iG(g), .iB(b),
    .iMODE(mode_v), .iMASK(mask_v), .iKEY_CH(key_v), .iTHRESH(thr_v), .iCFG_WR(cfg_wr),
    .oR(o_r), .oG(o_g), .oB(o_b), .oDE(o_de), .oVS(o_vs),
    .oMATCH_CNT(o_cnt), .oCNT_VALID(o_cv)
  );

  colour_filter_pipe #(.CNT_W(4)) dut4 (
    .iCLK(clk), .iRST(rst), .iVS(vs), .iDE(de), .iR(r), .iG(g), .iB(b),
    .iMODE(mode_v), .iMASK(mask_v), .iKEY_CH(key_v), .iTHRESH(thr_v), .iCFG_WR(cfg_wr),
    .oR(o4_r), .oG(o4_g), .oB(o4_b), .oDE(o4_de), .oVS(o4_vs),
    .oMATCH_CNT(o4_cnt), .oCNT_VALID(o4_cv)
  );

  typedef struct {
    int unsigned cyc;
    logic [24:0] px;
    logic        vs;
    logic        cv;
    logic [19:0] c20;
    logic [3:0]  c4;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int unsigned cyc = 0;
  int n_cmp = 0, n_mis = 0;

  // reference model state
  logic       m_prev;
  logic [1:0] p_mode, a_mode, p_key, a_key;
  logic [2:0] p_mask, a_mask;
  logic [7:0] p_thr, a_thr;
  int unsigned acc20, rep20, acc4, rep4;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && q.size() > 0 && q[0].cyc + 3 == cyc) begin
      mon_e = q.pop_front();
      check_val("px",   {7'd0, o_de, o_r, o_g, o_b}, {7'd0, mon_e.px});
      check_val("px4",  {7'd0, o4_de, o4_r, o4_g, o4_b}, {7'd0, mon_e.px});
      check_val("vs",   {31'd0, o_vs}, {31'd0, mon_e.vs});
      check_val("cv",   {31'd0, o_cv}, {31'd0, mon_e.cv});
      check_val("cv4",  {31'd0, o4_cv}, {31'd0, mon_e.cv});
      check_val("cnt",  {12'd0, o_cnt}, {12'd0, mon_e.c20});
      check_val("cnt4", {28'd0, o4_cnt}, {28'd0, mon_e.c4});
    end
  end

  task automatic model_reset();
    m_prev = 1'b0;
    p_mode = 2'd0; a_mode = 2'd0; p_key = 2'd0; a_key = 2'd0;
    p_mask = 3'b111; a_mask = 3'b111; p_thr = 8'd0; a_thr = 8'd0;
    acc20 = 0; rep20 = 0; acc4 = 0; rep4 = 0;
  endtask

  task automatic drive(input logic v, input logic d, input int rr, input int gg,
                       input int bb, input logic w);
    int y, k, o1, o2, er, eg, eb;
    logic match, hit, edge_m;
    exp_t e;
    @(negedge clk);
    vs = v; de = d; r = 8'(rr); g = 8'(gg); b = 8'(bb); cfg_wr = w;
    edge_m = v && !m_prev;
    m_prev = v;
    if (edge_m) begin
      if (w) begin a_mode = mode_v; a_mask = mask_v; a_key = key_v; a_thr = thr_v; end
      else begin a_mode = p_mode; a_mask = p_mask; a_key = p_key; a_thr = p_thr; end
    end
    if (w) begin p_mode = mode_v; p_mask = mask_v; p_key = key_v; p_thr = thr_v; end
    y = (rr + 2 * gg + bb) / 4;
    case (a_key)
      2'd1:    begin k = gg; o1 = rr; o2 = bb; end
      2'd2:    begin k = bb; o1 = rr; o2 = gg; end
      default: begin k = rr; o1 = gg; o2 = bb; end
    endcase
    match = (k >= o1 + int'(a_thr)) && (k >= o2 + int'(a_thr));
    case (a_mode)
      2'd1:    begin er = y; eg = y; eb = y; end
      2'd2:    begin er = a_mask[2] ? rr : 0; eg = a_mask[1] ? gg : 0; eb = a_mask[0] ? bb : 0; end
      2'd3:    begin er = match ? rr : y; eg = match ? gg : y; eb = match ? bb : y; end
      default: begin er = rr; eg = gg; eb = bb; end
    endcase
    if (!d) begin er = 0; eg = 0; eb = 0; end
    hit = d && (a_mode == 2'd3) && match;
    if (edge_m) begin
      rep20 = acc20; rep4 = acc4;
      acc20 = hit ? 1 : 0; acc4 = hit ? 1 : 0;
    end else if (hit) begin
      if (acc20 < 20'hFFFFF) acc20++;
      if (acc4 < 15) acc4++;
    end
    e.cyc = cyc;
    e.px  = {d, 8'(er), 8'(eg), 8'(eb)};
    e.vs  = v;
    e.cv  = edge_m;
    e.c20 = 20'(rep20);
    e.c4  = 4'(rep4);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic vs_pulse();
    drive(1'b1, 1'b0, 0, 0, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 0, 0, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; vs = 1'b0; de = 1'b0; cfg_wr = 1'b0; r = '0; g = '0; b = '0;
    q.delete();
    model_reset();
    @(posedge clk); #1;
    check_val("rst_px",   {7'd0, o_de, o_r, o_g, o_b}, 32'd0);
    check_val("rst_vs",   {31'd0, o_vs}, 32'd0);
    check_val("rst_cv",   {31'd0, o_cv}, 32'd0);
    check_val("rst_cnt",  {12'd0, o_cnt}, 32'd0);
    check_val("rst_cnt4", {28'd0, o4_cnt}, 32'd0);
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    do_reset(2);

    // T1: pass-through latency
    idle(3);
    drive(1'b0, 1'b1, 10, 20, 30, 1'b0);
    idle(4);

    // T2: greyscale
    mode_v = 2'd1;
    drive(1'b0, 1'b0, 0, 0, 0, 1'b1);
    vs_pulse();
    drive(1'b0, 1'b1, 100, 200, 40, 1'b0);
    drive(1'b0, 1'b1, 255, 255, 255, 1'b0);
    idle(2);

    // T3: mask with shadowing and pending overwrite
    mode_v = 2'd2; mask_v = 3'b011;
    drive(1'b0, 1'b1, 50, 60, 70, 1'b1);
    mask_v = 3'b101;
    drive(1'b0, 1'b1, 50, 60, 70, 1'b1);
    drive(1'b0, 1'b1, 50, 60, 70, 1'b0);
    vs_pulse();
    drive(1'b0, 1'b1, 50, 60, 70, 1'b0);
    idle(2);

    // T4: colour key on G, equality boundary and no-wrap case
    mode_v = 2'd3; key_v = 2'd1; thr_v = 8'd20;
    drive(1'b0, 1'b0, 0, 0, 0, 1'b1);
    vs_pulse();
    drive(1'b0, 1'b1, 10, 30, 10, 1'b0);
    drive(1'b0, 1'b1, 11, 30, 10, 1'b0);
    thr_v = 8'd10;
    drive(1'b1, 1'b0, 0, 0, 0, 1'b1);
    drive(1'b1, 1'b0, 0, 0, 0, 1'b0);
    drive(1'b0, 1'b1, 0, 255, 250, 1'b0);
    idle(2);

    // T5: 7 matches + 5 misses, then a match coincident with the edge
    vs_pulse();
    for (int i = 0; i < 12; i++) begin
      if (i == 1 || i == 3 || i == 5 || i == 7 || i == 9)
        drive(1'b0, 1'b1, 50, 50, 50, 1'b0);
      else
        drive(1'b0, 1'b1, 0, 100, 0, 1'b0);
    end
    drive(1'b1, 1'b1, 0, 100, 0, 1'b0);
    drive(1'b0, 1'b1, 0, 100, 0, 1'b0);
    drive(1'b0, 1'b1, 50, 50, 50, 1'b0);
    vs_pulse();
    idle(4);

    // T6: saturation, then mid-frame reset
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 0, 100, 0, 1'b0);
    vs_pulse();
    idle(4);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 0, 100, 0, 1'b0);
    do_reset(2);
    idle(5);
    mode_v = 2'd3; key_v = 2'd1; thr_v = 8'd10;
    drive(1'b0, 1'b0, 0, 0, 0, 1'b1);
    drive(1'b0, 1'b1, 0, 100, 0, 1'b0);
    drive(1'b0, 1'b1, 0, 100, 0, 1'b0);
    vs_pulse();
    drive(1'b0, 1'b1, 0, 100, 0, 1'b0);
    drive(1'b0, 1'b1, 0, 100, 0, 1'b0);
    vs_pulse();
    idle(4);

    repeat (5) @(posedge clk);
    #1;
    check_val("drain", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
